pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Detects RAW data hazards and issues stall and bubble controls to the PC and the IF_ID/ID_EX registers.
- Squashes wrong-path instructions on a taken branch (EX) or jump (ID).
- Drains the pipeline on HLT before asserting the processor-level hlt.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_raw_detect.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the 5-stage pipeline hazard
//               control slice (sequencer states, register-zero, NOP word).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // R0 is hard-wired to zero and never produces a hazard
    localparam logic [3:0]  REG_ZERO  = 4'h0;

    // Encoding loaded into a pipeline register to squash its instruction
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // True when the ID instruction reads register addr (addr must be nonzero)
    function automatic logic reg_match(
        input logic [3:0] addr,
        input logic [3:0] rs,
        input logic [3:0] rt,
        input logic       rs_use,
        input logic       rt_use
    );
        return (addr != REG_ZERO) &&
               ((rs_use && (rs == addr)) || (rt_use && (rt == addr)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_raw_detect.sv
`default_nettype none
// ============================================================================
// Module      : raw_detect
// Description : Combinational RAW comparator of the ID sources against the
//               EX and MEM producers. With forwarding only a load in EX is a
//               hazard; without it any writing producer in EX or MEM is.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_detect
    import pipe_pkg::*;
#(
    parameter bit FWD_EN = 1'b0
) (
    input  logic [3:0] rs_ID,
    input  logic [3:0] rt_ID,
    input  logic       rs_use_ID,
    input  logic       rt_use_ID,
    input  logic [3:0] dst_addr_EX,
    input  logic       we_rf_EX,
    input  logic       re_mem_EX,
    input  logic [3:0] dst_addr_MEM,
    input  logic       we_rf_MEM,
    output logic       hz_ex,
    output logic       hz_mem
);

    logic w_match_ex;
    logic w_match_mem;

    // Source/destination comparison against each producer stage
    always_comb begin
        w_match_ex  = reg_match(dst_addr_EX,  rs_ID, rt_ID, rs_use_ID, rt_use_ID);
        w_match_mem = reg_match(dst_addr_MEM, rs_ID, rt_ID, rs_use_ID, rt_use_ID);
    end

    // Qualify matches with write enables and the forwarding capability
    always_comb begin
        hz_ex  = we_rf_EX && w_match_ex && (FWD_EN ? re_mem_EX : 1'b1);
        hz_mem = FWD_EN ? 1'b0 : (we_rf_MEM && w_match_mem);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central sequencer for the IF/ID/EX/MEM/WB pipeline. Stalls on
//               RAW hazards, squashes wrong-path instructions on taken
//               branches and jumps, drains the pipe on HLT and keeps
//               saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit FWD_EN       = 1'b0,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rs_ID,
    input  logic [3:0]       rt_ID,
    input  logic             rs_use_ID,
    input  logic             rt_use_ID,
    input  logic             j_ctrl_ID,
    input  logic             hlt_ID,
    input  logic [3:0]       dst_addr_EX,
    input  logic             we_rf_EX,
    input  logic             re_mem_EX,
    input  logic [3:0]       dst_addr_MEM,
    input  logic             we_rf_MEM,
    input  logic             br_ctrl_EX,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             jump_en,
    output logic             hlt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                   c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX    = {CNT_W{1'b1}};

    state_t               r_state;
    state_t               w_next_state;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [c_DRAIN_W-1:0] w_next_drain;
    logic                 r_hlt;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    logic w_hz_ex;
    logic w_hz_mem;
    logic w_raw;
    logic w_stall_pc;
    logic w_stall_if_id;
    logic w_flush_if_id;
    logic w_bubble_id_ex;
    logic w_jump_en;
    logic w_stall_inc;
    logic w_flush_inc;

    raw_detect #(
        .FWD_EN (FWD_EN)
    ) u_raw_detect (
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .rs_use_ID    (rs_use_ID),
        .rt_use_ID    (rt_use_ID),
        .dst_addr_EX  (dst_addr_EX),
        .we_rf_EX     (we_rf_EX),
        .re_mem_EX    (re_mem_EX),
        .dst_addr_MEM (dst_addr_MEM),
        .we_rf_MEM    (we_rf_MEM),
        .hz_ex        (w_hz_ex),
        .hz_mem       (w_hz_mem)
    );

    assign w_raw = w_hz_ex | w_hz_mem;

    // Mealy control outputs and next-state selection by event priority
    always_comb begin
        w_stall_pc     = 1'b0;
        w_stall_if_id  = 1'b0;
        w_flush_if_id  = 1'b0;
        w_bubble_id_ex = 1'b0;
        w_jump_en      = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_next_state   = r_state;
        w_next_drain   = r_drain_cnt;
        case (r_state)
            RUN: begin
                if (br_ctrl_EX) begin
                    // Younger instructions in IF/ID are wrong-path: ignore their hazards/HLT
                    w_flush_if_id  = 1'b1;
                    w_bubble_id_ex = 1'b1;
                    w_flush_inc    = 1'b1;
                end else if (w_raw) begin
                    // A pending jump waits here so its target is taken only once
                    w_stall_pc     = 1'b1;
                    w_stall_if_id  = 1'b1;
                    w_bubble_id_ex = 1'b1;
                    w_stall_inc    = 1'b1;
                end else if (j_ctrl_ID) begin
                    w_jump_en      = 1'b1;
                    w_flush_if_id  = 1'b1;
                    w_flush_inc    = 1'b1;
                end else if (hlt_ID) begin
                    // HLT itself moves on into ID_EX as a NOP
                    w_stall_pc     = 1'b1;
                    w_stall_if_id  = 1'b1;
                    w_stall_inc    = 1'b1;
                    w_next_drain   = c_DRAIN_LOAD;
                    w_next_state   = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
                end
            end
            DRAIN: begin
                w_stall_pc     = 1'b1;
                w_stall_if_id  = 1'b1;
                w_bubble_id_ex = 1'b1;
                w_stall_inc    = 1'b1;
                if (r_drain_cnt <= c_DRAIN_ONE) begin
                    w_next_drain = '0;
                    w_next_state = HALTED;
                end else begin
                    w_next_drain = r_drain_cnt - c_DRAIN_ONE;
                end
            end
            HALTED: begin
                w_stall_pc     = 1'b1;
                w_stall_if_id  = 1'b1;
                w_bubble_id_ex = 1'b1;
            end
            default: begin
                w_next_state = RUN;
                w_next_drain = '0;
            end
        endcase
    end

    // State, drain counter, sticky halt flag and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_hlt       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain;
            r_hlt       <= (w_next_state == HALTED);
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign stall_pc     = w_stall_pc;
    assign stall_if_id  = w_stall_if_id;
    assign flush_if_id  = w_flush_if_id;
    assign bubble_id_ex = w_bubble_id_ex;
    assign jump_en      = w_jump_en;
    assign hlt          = r_hlt;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed bench for pipe_hazard_ctrl. One instance without
//               forwarding (16-bit counters), one with forwarding (3-bit
//               counters so saturation is reachable). Both share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rs_ID, rt_ID, dst_addr_EX, dst_addr_MEM;
    logic       rs_use_ID, rt_use_ID, j_ctrl_ID, hlt_ID;
    logic       we_rf_EX, re_mem_EX, we_rf_MEM, br_ctrl_EX;

    logic        stall_pc_f0, stall_if_id_f0, flush_if_id_f0, bubble_f0, jump_en_f0, hlt_f0;
    logic [15:0] stall_cnt_f0, flush_cnt_f0;
    logic        stall_pc_f1, stall_if_id_f1, flush_if_id_f1, bubble_f1, jump_en_f1, hlt_f1;
    logic [2:0]  stall_cnt_f1, flush_cnt_f1;

    int total;
    int bad;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .DRAIN_CYCLES(3), .CNT_W(16)) dut_f0 (
        .clk(clk), .rst_n(rst_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID),
        .j_ctrl_ID(j_ctrl_ID), .hlt_ID(hlt_ID),
        .dst_addr_EX(dst_addr_EX), .we_rf_EX(we_rf_EX), .re_mem_EX(re_mem_EX),
        .dst_addr_MEM(dst_addr_MEM), .we_rf_MEM(we_rf_MEM), .br_ctrl_EX(br_ctrl_EX),
        .stall_pc(stall_pc_f0), .stall_if_id(stall_if_id_f0), .flush_if_id(flush_if_id_f0),
        .bubble_id_ex(bubble_f0), .jump_en(jump_en_f0), .hlt(hlt_f0),
        .stall_cnt(stall_cnt_f0), .flush_cnt(flush_cnt_f0)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .DRAIN_CYCLES(3), .CNT_W(3)) dut_f1 (
        .clk(clk), .rst_n(rst_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID),
        .j_ctrl_ID(j_ctrl_ID), .hlt_ID(hlt_ID),
        .dst_addr_EX(dst_addr_EX), .we_rf_EX(we_rf_EX), .re_mem_EX(re_mem_EX),
        .dst_addr_MEM(dst_addr_MEM), .we_rf_MEM(we_rf_MEM), .br_ctrl_EX(br_ctrl_EX),
        .stall_pc(stall_pc_f1), .stall_if_id(stall_if_id_f1), .flush_if_id(flush_if_id_f1),
        .bubble_id_ex(bubble_f1), .jump_en(jump_en_f1), .hlt(hlt_f1),
        .stall_cnt(stall_cnt_f1), .flush_cnt(flush_cnt_f1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs_ID = 4'd0; rt_ID = 4'd0; rs_use_ID = 1'b0; rt_use_ID = 1'b0;
        j_ctrl_ID = 1'b0; hlt_ID = 1'b0;
        dst_addr_EX = 4'd0; we_rf_EX = 1'b0; re_mem_EX = 1'b0;
        dst_addr_MEM = 4'd0; we_rf_MEM = 1'b0; br_ctrl_EX = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_pc", stall_pc_f0, 0);
        chk("rst_flush",    flush_if_id_f0, 0);
        chk("rst_bubble",   bubble_f0, 0);
        chk("rst_jump",     jump_en_f0, 0);
        chk("rst_hlt",      hlt_f0, 0);
        chk("rst_stall_cnt", stall_cnt_f0, 0);
        chk("rst_flush_cnt", flush_cnt_f0, 0);
        rst_n = 1'b1;
        next_cycle();

        // Load-use: load to R3 in EX, ID reads rs=R3
        idle(); dst_addr_EX = 4'd3; we_rf_EX = 1'b1; re_mem_EX = 1'b1; rs_ID = 4'd3; rs_use_ID = 1'b1;
        @(negedge clk);
        chk("lu_stall_pc_f1",    stall_pc_f1, 1);
        chk("lu_stall_if_id_f1", stall_if_id_f1, 1);
        chk("lu_bubble_f1",      bubble_f1, 1);
        chk("lu_stall_pc_f0",    stall_pc_f0, 1);
        next_cycle();
        idle(); dst_addr_MEM = 4'd3; we_rf_MEM = 1'b1; rs_ID = 4'd3; rs_use_ID = 1'b1;
        @(negedge clk);
        chk("lu_clear_f1", stall_pc_f1, 0);
        chk("lu_cnt_f1",   stall_cnt_f1, 1);
        chk("lu_mem_f0",   stall_pc_f0, 1);
        next_cycle();

        // No-forward RAW: ADD to R5 in EX then MEM, ID reads rt=R5
        idle(); dst_addr_EX = 4'd5; we_rf_EX = 1'b1; rt_ID = 4'd5; rt_use_ID = 1'b1;
        @(negedge clk);
        chk("nf_ex_f0", stall_pc_f0, 1);
        chk("nf_ex_f1", stall_pc_f1, 0);
        next_cycle();
        idle(); dst_addr_MEM = 4'd5; we_rf_MEM = 1'b1; rt_ID = 4'd5; rt_use_ID = 1'b1;
        @(negedge clk);
        chk("nf_mem_f0", stall_pc_f0, 1);
        chk("nf_mem_f1", stall_pc_f1, 0);
        next_cycle();
        idle(); rt_ID = 4'd5; rt_use_ID = 1'b1;
        @(negedge clk);
        chk("nf_wb_f0",  stall_pc_f0, 0);
        chk("nf_cnt_f0", stall_cnt_f0, 4);
        next_cycle();
        idle(); dst_addr_EX = 4'd0; we_rf_EX = 1'b1; dst_addr_MEM = 4'd0; we_rf_MEM = 1'b1;
        rt_ID = 4'd0; rt_use_ID = 1'b1;
        @(negedge clk);
        chk("r0_f0", stall_pc_f0, 0);
        next_cycle();
        idle(); dst_addr_EX = 4'd5; we_rf_EX = 1'b1; rs_ID = 4'd5; rt_ID = 4'd5;
        @(negedge clk);
        chk("nouse_f0", stall_pc_f0, 0);
        next_cycle();

        // Taken branch over a pending stall and jump
        idle(); br_ctrl_EX = 1'b1; j_ctrl_ID = 1'b1;
        dst_addr_EX = 4'd3; we_rf_EX = 1'b1; re_mem_EX = 1'b1; rs_ID = 4'd3; rs_use_ID = 1'b1;
        @(negedge clk);
        chk("br_flush_f0",  flush_if_id_f0, 1);
        chk("br_bubble_f0", bubble_f0, 1);
        chk("br_stall_f0",  stall_pc_f0, 0);
        chk("br_jump_f0",   jump_en_f0, 0);
        chk("br_stall_f1",  stall_pc_f1, 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("br_fcnt_f0", flush_cnt_f0, 1);
        chk("br_scnt_f0", stall_cnt_f0, 4);
        chk("br_fcnt_f1", flush_cnt_f1, 1);

        // Jump held off during a one-cycle EX hazard
        next_cycle();
        idle(); j_ctrl_ID = 1'b1; dst_addr_EX = 4'd7; we_rf_EX = 1'b1; re_mem_EX = 1'b1;
        rs_ID = 4'd7; rs_use_ID = 1'b1;
        @(negedge clk);
        chk("jst_c0_jump_f0", jump_en_f0, 0);
        chk("jst_c0_jump_f1", jump_en_f1, 0);
        chk("jst_c0_stall_f1", stall_pc_f1, 1);
        next_cycle();
        idle(); j_ctrl_ID = 1'b1;
        @(negedge clk);
        chk("jst_c1_jump_f0",  jump_en_f0, 1);
        chk("jst_c1_flush_f0", flush_if_id_f0, 1);
        chk("jst_c1_jump_f1",  jump_en_f1, 1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("jst_fcnt_f0", flush_cnt_f0, 2);
        chk("jst_fcnt_f1", flush_cnt_f1, 2);
        chk("jst_scnt_f0", stall_cnt_f0, 5);
        chk("jst_scnt_f1", stall_cnt_f1, 2);

        // Saturation: six more load-use stalls; 3-bit counter stops at 7
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            idle(); dst_addr_EX = 4'd2; we_rf_EX = 1'b1; re_mem_EX = 1'b1; rt_ID = 4'd2; rt_use_ID = 1'b1;
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk("sat_scnt_f1", stall_cnt_f1, 7);
        chk("sat_scnt_f0", stall_cnt_f0, 11);

        // Halt drain: hlt_ID accepted at cycle t, hlt rises at t+3
        next_cycle();
        idle(); hlt_ID = 1'b1;
        @(negedge clk);
        chk("h_t0_stall_pc", stall_pc_f0, 1);
        chk("h_t0_stall_if", stall_if_id_f0, 1);
        chk("h_t0_bubble",   bubble_f0, 0);
        chk("h_t0_hlt",      hlt_f0, 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("h_t1_bubble", bubble_f0, 1);
        chk("h_t1_stall",  stall_pc_f0, 1);
        chk("h_t1_hlt",    hlt_f0, 0);
        next_cycle();
        @(negedge clk);
        chk("h_t2_hlt", hlt_f0, 0);
        next_cycle();
        idle(); j_ctrl_ID = 1'b1;
        @(negedge clk);
        chk("h_t3_hlt",    hlt_f0, 1);
        chk("h_t3_hlt_f1", hlt_f1, 1);
        chk("h_t3_jump",   jump_en_f0, 0);
        chk("h_t3_bubble", bubble_f0, 1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("h_t4_hlt",  hlt_f0, 1);
        chk("h_t4_fcnt", flush_cnt_f0, 2);

        // Asynchronous reset out of HALTED
        #1 rst_n = 1'b0;
        #1;
        chk("hr_hlt",   hlt_f0, 0);
        chk("hr_stall", stall_pc_f0, 0);
        chk("hr_fcnt",  flush_cnt_f0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Reset while draining at drain count 1
        idle(); hlt_ID = 1'b1;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        chk("rd_pre_stall", stall_pc_f0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rd_stall",  stall_pc_f0, 0);
        chk("rd_bubble", bubble_f0, 0);
        chk("rd_hlt",    hlt_f0, 0);
        chk("rd_scnt",   stall_cnt_f0, 0);
        chk("rd_scnt_f1", stall_cnt_f1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        chk("rd_resume_stall", stall_pc_f0, 0);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rd_no_hlt", hlt_f0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
